// File: rtl/fadd_arb_pkg.sv
// Shared types and constants for the FP32 adder-sharing arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package fadd_arb_pkg;

   localparam int N_REQ_DEF    = 4;
   localparam int FADD_LATENCY = 3;

   // Tag ids are sized for the largest supported requester count (8) so the
   // struct does not depend on the top-level parameter.
   localparam int N_REQ_MAX = 8;
   localparam int TAG_ID_W  = $clog2(N_REQ_MAX);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      HELD  = 2'd2
   } arb_state_t;

   typedef struct packed {
      logic                valid;
      logic [TAG_ID_W-1:0] id;
   } tag_t;

endpackage

// File: rtl/fadd_share_arb_rr_pick.sv
// Round-robin picker: first set bit of req, searching cyclically from ptr.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the pick is used.
// Ports: req (candidates), ptr (search start), gnt (one-hot pick),
//        idx (binary index of pick), any (some candidate was found).
module rr_pick
   import fadd_arb_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx,
   output logic          any
);

   always_comb begin
      gnt = '0;
      idx = '0;
      any = 1'b0;
      for (int k = 0; k < N; k++) begin
         int j;
         j = int'(ptr) + k;
         if (j >= N) j = j - N;
         if (!any && req[j]) begin
            any    = 1'b1;
            gnt[j] = 1'b1;
            idx    = IW'(j);
         end
      end
   end

endmodule

// File: rtl/fadd_share_arb.sv
// Time-shares one pipelined FP32 adder between N_REQ requesters, round-robin.
// Latency: handshake to resp_valid is LATENCY+1 edges; one issue per cycle.
// Backpressure: req_ready grants at most one requester per cycle (none while
//               draining/held); responses have no backpressure.
// Ports: clk/rstn; req_valid/req_ready/req_a/req_b/req_sub per requester;
//        resp_valid (one-hot strobe) + shared resp_data; hold/idle quiesce;
//        busy; fadd_a/fadd_b registered adder operands, fadd_c adder result.
module fadd_share_arb
   import fadd_arb_pkg::*;
#(
   parameter int N_REQ   = N_REQ_DEF,
   parameter int LATENCY = FADD_LATENCY
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic [N_REQ-1:0]       req_valid,
   output logic [N_REQ-1:0]       req_ready,
   input  logic [N_REQ-1:0][31:0] req_a,
   input  logic [N_REQ-1:0][31:0] req_b,
   input  logic [N_REQ-1:0]       req_sub,
   output logic [N_REQ-1:0]       resp_valid,
   output logic [31:0]            resp_data,
   input  logic                   hold,
   output logic                   idle,
   output logic                   busy,
   output logic [31:0]            fadd_a,
   output logic [31:0]            fadd_b,
   input  logic [31:0]            fadd_c
);

   localparam int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CNT_W = $clog2(LATENCY + 3);

   arb_state_t         state_q, state_d;
   logic [IW-1:0]      ptr_q;
   logic [N_REQ-1:0]   pick_gnt;
   logic [IW-1:0]      pick_idx;
   logic               pick_any;
   logic               issue;
   tag_t               tag_in;
   tag_t               tag_q [LATENCY+1];
   tag_t               tag_out;
   logic [N_REQ-1:0]   resp_hit;
   logic [CNT_W-1:0]   cnt_q;

   rr_pick #(
      .N  (N_REQ),
      .IW (IW)
   ) u_pick (
      .req (req_valid),
      .ptr (ptr_q),
      .gnt (pick_gnt),
      .idx (pick_idx),
      .any (pick_any)
   );

   // ---------------------------------------------------------------
   // Control FSM. Grants are only offered in RUN; rstn also masks them
   // so req_ready reads 0 while reset is held.
   // ---------------------------------------------------------------
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state_q <= RUN;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      req_ready = '0;
      issue     = 1'b0;
      case (state_q)
         RUN: begin
            if (rstn) begin
               req_ready = pick_gnt;
               // pick_gnt is a subset of req_valid, so a pick is a handshake
               issue     = pick_any;
            end
            if (hold) state_d = DRAIN;
         end
         DRAIN: begin
            if (!hold)               state_d = RUN;
            else if (cnt_q == '0)    state_d = HELD;
         end
         HELD: begin
            if (!hold) state_d = RUN;
         end
         default: state_d = RUN;
      endcase
   end

   assign idle = (state_q == HELD);
   assign busy = (cnt_q != '0);

   // ---------------------------------------------------------------
   // Pointer and issue registers
   // ---------------------------------------------------------------
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ptr_q  <= '0;
         fadd_a <= '0;
         fadd_b <= '0;
      end else if (issue) begin
         ptr_q  <= (pick_idx == IW'(N_REQ - 1)) ? '0 : pick_idx + IW'(1);
         fadd_a <= req_a[pick_idx];
         // subtraction is addition with the sign of b flipped
         fadd_b <= req_b[pick_idx] ^ {req_sub[pick_idx], 31'b0};
      end
   end

   // ---------------------------------------------------------------
   // Tag pipeline: stage 0 is aligned with fadd_a/fadd_b, the last
   // stage is aligned with fadd_c.
   // ---------------------------------------------------------------
   always_comb begin
      tag_in.valid = issue;
      tag_in.id    = issue ? TAG_ID_W'(pick_idx) : '0;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int k = 0; k <= LATENCY; k++) tag_q[k] <= '0;
      end else begin
         tag_q[0] <= tag_in;
         for (int k = 1; k <= LATENCY; k++) tag_q[k] <= tag_q[k-1];
      end
   end

   assign tag_out = tag_q[LATENCY];

   always_comb begin
      resp_hit = '0;
      for (int i = 0; i < N_REQ; i++)
         resp_hit[i] = tag_out.valid && (tag_out.id == TAG_ID_W'(i));
   end

   // ---------------------------------------------------------------
   // Response register
   // ---------------------------------------------------------------
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         resp_valid <= '0;
         resp_data  <= '0;
      end else begin
         resp_valid <= resp_hit;
         if (tag_out.valid) resp_data <= fadd_c;
      end
   end

   // ---------------------------------------------------------------
   // In-flight counter: issue to response load
   // ---------------------------------------------------------------
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_q <= '0;
      end else begin
         case ({issue, tag_out.valid})
            2'b10:   cnt_q <= cnt_q + CNT_W'(1);
            2'b01:   cnt_q <= cnt_q - CNT_W'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: tb/tb_fadd_share_arb.sv
// Randomized scoreboard bench for fadd_share_arb with an integer-valued FP32 adder stub.
module tb_fadd_share_arb;

   localparam int N   = 4;
   localparam int LAT = 3;
   localparam int QD  = 128;

   logic               clk = 1'b0;
   logic               rstn;
   logic [N-1:0]       req_valid;
   logic [N-1:0]       req_ready;
   logic [N-1:0][31:0] req_a;
   logic [N-1:0][31:0] req_b;
   logic [N-1:0]       req_sub;
   logic [N-1:0]       resp_valid;
   logic [31:0]        resp_data;
   logic               hold;
   logic               idle;
   logic               busy;
   logic [31:0]        fadd_a;
   logic [31:0]        fadd_b;
   logic [31:0]        fadd_c;

   fadd_share_arb #(.N_REQ(N), .LATENCY(LAT)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_sub    (req_sub),
      .resp_valid (resp_valid),
      .resp_data  (resp_data),
      .hold       (hold),
      .idle       (idle),
      .busy       (busy),
      .fadd_a     (fadd_a),
      .fadd_b     (fadd_b),
      .fadd_c     (fadd_c)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   // ---------------- FP32 <-> small integer helpers ----------------
   function automatic logic [31:0] fp_of_int(input int v);
      logic [31:0] r;
      int m, p;
      if (v == 0) return 32'h0;
      m = (v < 0) ? -v : v;
      p = 0;
      for (int k = 0; k < 31; k++) if (m >= (1 << k)) p = k;
      r[31]    = (v < 0);
      r[30:23] = 8'(127 + p);
      r[22:0]  = 23'((m << (23 - p)) & 32'h007F_FFFF);
      return r;
   endfunction

   function automatic int int_of_fp(input logic [31:0] f);
      int e, m, v;
      if (f[30:0] == 31'h0) return 0;
      e = int'(f[30:23]) - 127;
      m = int'({8'h0, 1'b1, f[22:0]});
      if (e < 0)        v = 0;
      else if (e <= 23) v = m >> (23 - e);
      else              v = m << (e - 23);
      return f[31] ? -v : v;
   endfunction

   // Adder stub: three unreset stages, exact for integer-valued operands.
   logic [31:0] s1, s2, s3;
   always @(posedge clk) begin
      s1 <= fp_of_int(int_of_fp(fadd_a) + int_of_fp(fadd_b));
      s2 <= s1;
      s3 <= s2;
   end
   assign fadd_c = s3;

   // ---------------- stimulus storage and scoreboard ----------------
   logic [31:0] op_a [N][QD];
   logic [31:0] op_b [N][QD];
   logic        op_s [N][QD];
   logic [31:0] op_e [N][QD];
   int          head [N];
   int          tail [N];

   typedef struct {
      int          id;
      logic [31:0] data;
      int          cyc;
   } sb_t;

   sb_t sb[$];
   int  gnt_log[$];
   int  resp_log[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic timeout(input string nm);
      checks++;
      errors++;
      $display("FAIL %s: timed out at cycle %0d", nm, cyc);
   endtask

   task automatic enq(input int r, input logic [31:0] a, input logic [31:0] b,
                      input logic s, input logic [31:0] e);
      if (tail[r] < QD) begin
         op_a[r][tail[r]] = a;
         op_b[r][tail[r]] = b;
         op_s[r][tail[r]] = s;
         op_e[r][tail[r]] = e;
         tail[r]++;
      end
   endtask

   // Reference: the sum/difference of two random integers, as FP32.
   task automatic enq_rand(input int r);
      int x, y;
      logic s;
      x = int'($urandom_range(4000)) - 2000;
      y = int'($urandom_range(4000)) - 2000;
      s = 1'($urandom_range(1));
      enq(r, fp_of_int(x), fp_of_int(y), s, fp_of_int(s ? x - y : x + y));
   endtask

   // ---------------- driver: hold valid+operands until handshake ----------------
   initial begin
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      req_sub   = '0;
      forever begin
         @(posedge clk);
         #1;
         for (int i = 0; i < N; i++) begin
            if (head[i] < tail[i]) begin
               req_valid[i] = 1'b1;
               req_a[i]     = op_a[i][head[i]];
               req_b[i]     = op_b[i][head[i]];
               req_sub[i]   = op_s[i][head[i]];
            end else begin
               req_valid[i] = 1'b0;
            end
         end
         @(negedge clk);
         if (rstn) begin
            for (int i = 0; i < N; i++) begin
               if (req_valid[i] && req_ready[i]) begin
                  sb.push_back('{id: i, data: op_e[i][head[i]], cyc: cyc});
                  gnt_log.push_back(i);
                  head[i]++;
               end
            end
         end
      end
   end

   // ---------------- monitor ----------------
   initial begin
      forever begin
         @(negedge clk);
         if (rstn && resp_valid != '0) begin
            if (sb.size() == 0) begin
               timeout("resp_unexpected");
            end else begin
               sb_t e;
               logic [N-1:0] oh;
               e  = sb.pop_front();
               oh = '0;
               oh[e.id] = 1'b1;
               chk("resp_valid_onehot", 32'(resp_valid), 32'(oh));
               chk("resp_data", resp_data, e.data);
               chk("resp_latency", 32'(cyc - e.cyc), 32'd5);
               resp_log.push_back(cyc);
            end
         end
      end
   end

   // ---------------- helpers for the main sequence ----------------
   function automatic bit all_issued();
      for (int i = 0; i < N; i++) if (head[i] < tail[i]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic wait_log(input int n, input int lim, input string nm);
      int k = 0;
      while (gnt_log.size() < n && k < lim) begin
         @(negedge clk);
         #1;
         k++;
      end
      if (gnt_log.size() < n) timeout(nm);
   endtask

   task automatic drain(input int lim, input string nm);
      int k = 0;
      while (!(all_issued() && sb.size() == 0 && !busy) && k < lim) begin
         @(negedge clk);
         #1;
         k++;
      end
      if (!(all_issued() && sb.size() == 0 && !busy)) timeout(nm);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_req_ready"},  32'(req_ready),  32'h0);
      chk({tag, "_resp_valid"}, 32'(resp_valid), 32'h0);
      chk({tag, "_resp_data"},  resp_data,       32'h0);
      chk({tag, "_fadd_a"},     fadd_a,          32'h0);
      chk({tag, "_fadd_b"},     fadd_b,          32'h0);
      chk({tag, "_busy"},       32'(busy),       32'h0);
      chk({tag, "_idle"},       32'(idle),       32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      for (int i = 0; i < N; i++) begin
         head[i] = 0;
         tail[i] = 0;
      end
      rstn = 1'b0;
      hold = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("rst0");
      rstn = 1'b1;
      @(negedge clk);
      #1;

      // Fairness: all requesters valid for two rounds from pointer 0.
      gnt_log.delete();
      for (int r = 0; r < 2; r++)
         for (int i = 0; i < N; i++) enq_rand(i);
      wait_log(8, 50, "fair_grants");
      for (int k = 0; k < 8 && k < gnt_log.size(); k++)
         chk("fair_order", 32'(gnt_log[k]), 32'(k % N));
      drain(100, "fair_drain");

      // Single add on requester 1: 1.0 + 2.0 = 3.0
      enq(1, 32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000);
      drain(50, "single_drain");

      // Subtract on requester 0: 2.0 - 1.0 = 1.0
      gnt_log.delete();
      enq(0, 32'h4000_0000, 32'h3F80_0000, 1'b1, 32'h3F80_0000);
      wait_log(1, 20, "sub_grant");
      @(negedge clk);
      chk("sub_fadd_a", fadd_a, 32'h4000_0000);
      chk("sub_fadd_b", fadd_b, 32'hBF80_0000);
      #1;
      drain(50, "sub_drain");

      // Back-to-back on requester 2.
      gnt_log.delete();
      resp_log.delete();
      for (int k = 0; k < 5; k++) enq_rand(2);
      drain(60, "b2b_drain");
      chk("b2b_grants", 32'(gnt_log.size()), 32'd5);
      foreach (gnt_log[k]) chk("b2b_grant_id", 32'(gnt_log[k]), 32'd2);
      chk("b2b_resp_count", 32'(resp_log.size()), 32'd5);
      if (resp_log.size() == 5)
         chk("b2b_resp_span", 32'(resp_log[4] - resp_log[0]), 32'd4);

      // Hold with three operations in flight; pointer sits at 3.
      gnt_log.delete();
      for (int i = 0; i < 3; i++) enq_rand(i);
      wait_log(3, 20, "hold_grants");
      hold = 1'b1;
      enq_rand(3);
      enq_rand(0);
      begin
         int k = 0;
         bit seen_idle = 1'b0;
         while (!seen_idle && k < 30) begin
            @(negedge clk);
            #1;
            chk("hold_no_grant", 32'(req_ready), 32'h0);
            chk("hold_busy", 32'(busy), 32'(sb.size() != 0));
            seen_idle = idle;
            k++;
         end
         if (!seen_idle) timeout("hold_idle");
      end
      chk("hold_all_returned", 32'(sb.size()), 32'd0);
      chk("hold_grant_count", 32'(gnt_log.size()), 32'd3);
      hold = 1'b0;
      wait_log(5, 20, "resume_grants");
      if (gnt_log.size() >= 5) begin
         chk("resume_first", 32'(gnt_log[3]), 32'd3);
         chk("resume_second", 32'(gnt_log[4]), 32'd0);
      end
      drain(60, "resume_drain");

      // Random traffic with random hold toggling.
      for (int t = 0; t < 120; t++) begin
         @(negedge clk);
         #1;
         if ($urandom_range(1) == 1) enq_rand(int'($urandom_range(N - 1)));
         if ($urandom_range(9) == 0) hold = ~hold;
      end
      hold = 1'b0;
      drain(600, "rand_drain");

      // Reset with two operations in flight.
      gnt_log.delete();
      enq_rand(1);
      enq_rand(2);
      wait_log(2, 20, "rst_grants");
      @(posedge clk);
      #2;
      for (int i = 0; i < N; i++) head[i] = tail[i];
      sb.delete();
      rstn = 1'b0;
      @(negedge clk);
      check_reset_outputs("rst1");
      @(negedge clk);
      rstn = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("post_rst_no_resp", 32'(resp_valid), 32'h0);
         chk("post_rst_busy", 32'(busy), 32'h0);
      end
      #1;
      gnt_log.delete();
      enq_rand(3);
      enq_rand(0);
      wait_log(1, 20, "post_rst_grant");
      if (gnt_log.size() >= 1) chk("post_rst_first_grant", 32'(gnt_log[0]), 32'd0);
      drain(60, "post_rst_drain");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
